// File: rtl/riscv_pkg.sv
// Shared core constants, register index type and ResultSrc encodings used by
// the writeback stage and the forwarding unit.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_RSV = 2'b11;

  // A write commits only when enabled and not aimed at the hardwired zero register.
  function automatic logic is_commit(input logic we, input reg_idx_t rd);
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: ALU result, load data or link address; the
// reserved encoding yields zero.
module wb_result_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [1:0]       src,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] read_data,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (src)
      RES_ALU: result = alu_result;
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32-entry register file with two async read
// ports and a committed-write counter. RF_BYPASS_EN enables write-before-read.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREG  = riscv_pkg::NREG,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcW,
  input  logic [XLEN-1:0]   ALUResultW,
  input  logic [XLEN-1:0]   ReadDataW,
  input  logic [XLEN-1:0]   PCPlus4W,
  input  logic [4:0]        RdW,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  output logic [XLEN-1:0]   RD1D,
  output logic [XLEN-1:0]   RD2D,
  output logic [XLEN-1:0]   ResultW,
  output logic [CNT_W-1:0]  WbCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0] regs [NREG];
  logic            commit;
  logic            bypass1;
  logic            bypass2;

  wb_result_mux #(.WIDTH(XLEN)) u_result_mux (
    .src       (ResultSrcW),
    .alu_result(ALUResultW),
    .read_data (ReadDataW),
    .pc_plus4  (PCPlus4W),
    .result    (ResultW)
  );

  assign commit = is_commit(RegWriteW, RdW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      WbCount <= '0;
    end else if (commit) begin
      regs[RdW] <= ResultW;
      WbCount   <= WbCount + CNT_ONE;
    end
  end

`ifdef RF_BYPASS_EN
  assign bypass1 = commit && (Rs1D == RdW);
  assign bypass2 = commit && (Rs2D == RdW);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // x0 reads are forced to zero regardless of array contents.
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (Rs1D != '0) begin
      RD1D = bypass1 ? ResultW : regs[Rs1D];
    end
    if (Rs2D != '0) begin
      RD2D = bypass2 ? ResultW : regs[Rs2D];
    end
  end

endmodule
